// File: rtl/div_seq_ctrl.sv
// Sequential non-restoring divider: one quotient bit per clock, signed via magnitude/sign fix-up.
// Optional zero-divisor short-cut enabled by defining DIV_ZERO_DETECT_EN.
module div_seq_ctrl #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic [2*WIDTH-1:0] out
);

   localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0]  IDLE = 2'd0;
   localparam logic [1:0]  ITER = 2'd1;
   localparam logic [1:0]  FIX  = 2'd2;

   logic [1:0]         state, state_d;
   logic [CW-1:0]      count, count_d;
   logic [WIDTH:0]     a, a_d;
   logic [WIDTH-1:0]   q, q_d, m, m_d;
   logic               neg_q, neg_q_d, neg_r, neg_r_d;
   logic               busy_d, done_d, dz_d;
   logic [2*WIDTH-1:0] out_d;

   logic               sgn_dd, sgn_ds;
   logic [WIDTH-1:0]   mag_dd, mag_ds;
   logic [WIDTH:0]     a_sh, a_step;
   logic [WIDTH-1:0]   r_fix, quo, rem;

   // Operand magnitudes; the most-negative value maps onto itself as an unsigned number.
   always_comb begin
      sgn_dd = SIGNED && dividend[WIDTH-1];
      sgn_ds = SIGNED && divisor[WIDTH-1];
      mag_dd = sgn_dd ? (~dividend) + WIDTH'(1) : dividend;
      mag_ds = sgn_ds ? (~divisor) + WIDTH'(1) : divisor;
   end

   // One non-restoring step and the final restore/sign correction.
   always_comb begin
      a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
      a_step = a[WIDTH] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
      r_fix  = a[WIDTH] ? a[WIDTH-1:0] + m : a[WIDTH-1:0];
      quo    = neg_q ? (~q) + WIDTH'(1) : q;
      rem    = neg_r ? (~r_fix) + WIDTH'(1) : r_fix;
   end

   always_comb begin
      state_d = state;
      count_d = count;
      a_d     = a;
      q_d     = q;
      m_d     = m;
      neg_q_d = neg_q;
      neg_r_d = neg_r;
      busy_d  = busy;
      done_d  = 1'b0;
      dz_d    = div_zero;
      out_d   = out;
      case (state)
         IDLE: begin
            if (start) begin
               dz_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
               if (divisor == '0) begin
                  out_d  = {dividend, {WIDTH{1'b1}}};
                  dz_d   = 1'b1;
                  done_d = 1'b1;
               end else
`endif
               begin
                  q_d     = mag_dd;
                  m_d     = mag_ds;
                  a_d     = '0;
                  count_d = '0;
                  neg_q_d = sgn_dd ^ sgn_ds;
                  neg_r_d = sgn_dd;
                  busy_d  = 1'b1;
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            a_d     = a_step;
            q_d     = {q[WIDTH-2:0], ~a_step[WIDTH]};
            count_d = count + CW'(1);
            if (count == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            out_d   = {rem, quo};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= IDLE;
         count    <= '0;
         a        <= '0;
         q        <= '0;
         m        <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         out      <= '0;
      end else begin
         state    <= state_d;
         count    <= count_d;
         a        <= a_d;
         q        <= q_d;
         m        <= m_d;
         neg_q    <= neg_q_d;
         neg_r    <= neg_r_d;
         busy     <= busy_d;
         done     <= done_d;
         div_zero <= dz_d;
         out      <= out_d;
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized bench for div_seq_ctrl against an arithmetic reference and a cycle-level timing model.
module tb_div_seq_ctrl;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 1;

   logic           clk = 1'b0;
   logic           clr, start;
   logic [W-1:0]   dividend, divisor;
   logic           busy, done, div_zero;
   logic [2*W-1:0] out;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   div_seq_ctrl #(.WIDTH(W), .SIGNED(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .div_zero(div_zero), .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] neg(input logic [W-1:0] x);
      return (~x) + W'(1);
   endfunction

   // Truncating signed division from plain unsigned arithmetic on magnitudes.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] dd, input logic [W-1:0] ds);
      logic [W-1:0] md, ms, qq, rr;
      md = dd[W-1] ? neg(dd) : dd;
      ms = ds[W-1] ? neg(ds) : ds;
      if (ms == '0) begin
         qq = '1;
         rr = md;
      end else begin
         qq = md / ms;
         rr = md % ms;
      end
      if (dd[W-1] ^ ds[W-1]) qq = neg(qq);
      if (dd[W-1]) rr = neg(rr);
      return {rr, qq};
   endfunction

   function automatic bit zero_short(input logic [W-1:0] ds);
`ifdef DIV_ZERO_DETECT_EN
      return ds == '0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [2*W-1:0] exp_out(input logic [W-1:0] dd, input logic [W-1:0] ds);
      if (zero_short(ds)) return {dd, {W{1'b1}}};
      return ref_div(dd, ds);
   endfunction

   // Timing model: a countdown of remaining busy cycles plus the pending result.
   bit             m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   logic [2*W-1:0] m_out = '0, m_pend = '0;
   int             m_left = 0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (!clr) begin
         m_busy = 1'b0;
         m_dz   = 1'b0;
         m_out  = '0;
         m_left = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_out  = m_pend;
         end
      end else if (start) begin
         if (zero_short(divisor)) begin
            m_out  = exp_out(dividend, divisor);
            m_dz   = 1'b1;
            m_done = 1'b1;
         end else begin
            m_pend = ref_div(dividend, divisor);
            m_dz   = 1'b0;
            m_busy = 1'b1;
            m_left = LAT;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("div_zero", 64'(div_zero), 64'(m_dz));
         check("out", out, m_out);
      end
   end

   task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] ds);
      dividend = dd;
      divisor  = ds;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // lat = cycles after the accepting edge's cycle until done is seen; bc = busy cycles.
   task automatic wait_done(output int lat, output int bc);
      lat = 0;
      bc  = 0;
      forever begin
         @(negedge clk);
         if (busy) bc++;
         if (done) break;
         lat++;
         if (lat > 200) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", LAT);
            break;
         end
      end
   endtask

   task automatic run_div(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds);
      int lat, bc;
      bit zs;
      zs = zero_short(ds);
      launch(dd, ds);
      wait_done(lat, bc);
      check({name, "_out"}, out, exp_out(dd, ds));
      check({name, "_lat"}, 64'(lat), zs ? 64'd0 : 64'(LAT));
      check({name, "_busycyc"}, 64'(bc), zs ? 64'd0 : 64'(LAT));
      check({name, "_dz"}, 64'(div_zero), 64'(zs));
   endtask

   typedef struct {
      logic [W-1:0]   dd;
      logic [W-1:0]   ds;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs[7] = '{
      '{32'd100,        32'd7,          64'h00000002_0000000E},
      '{32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2},
      '{32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2},
      '{32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E},
      '{32'h80000000,   32'd1,          64'h00000000_80000000},
      '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001},
      '{32'd55,         32'd0,          64'h00000037_FFFFFFFF}
   };

   initial begin
      int lat, bc;
      bit saw;
      logic [W-1:0] dd, ds;
      clr = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_out", out, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      clr = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases; the literal also pins the reference model.
      foreach (vecs[i]) begin
         check($sformatf("model_vec%0d", i), exp_out(vecs[i].dd, vecs[i].ds), vecs[i].exp);
         run_div($sformatf("vec%0d", i), vecs[i].dd, vecs[i].ds);
         check($sformatf("lit_vec%0d", i), out, vecs[i].exp);
      end

      // start while busy is ignored.
      launch(32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; dividend = 32'd77; divisor = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      check("repulse_out", out, 64'h00000001_0000014D);
      repeat (3) @(negedge clk);
      check("repulse_idle", 64'(busy), 64'd0);

      // Back-to-back: start accepted in the done cycle.
      launch(32'd5000, 32'd9);
      wait_done(lat, bc);
      check("b2b_first", out, 64'h00000005_0000022B);
      dividend = 32'hFFFFEC78; divisor = 32'd13; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      check("b2b_lat", 64'(lat), 64'(LAT));
      check("b2b_second", out, ref_div(32'hFFFFEC78, 32'd13));

      // Reset mid-division aborts with no done.
      launch(32'd12345, 32'd67);
      repeat (14) @(posedge clk);
      #1;
      clr = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b1;
      @(negedge clk);
      check("abort_out", out, 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      check("abort_no_done", 64'(saw), 64'd0);
      run_div("post_abort", 32'd12345, 32'd67);

      // Randomized divisions.
      for (int n = 0; n < 150; n++) begin
         dd = $urandom;
         case ($urandom_range(0, 3))
            0: begin
               ds = W'($urandom_range(1, 15));
               if ($urandom_range(0, 1) == 1) ds = neg(ds);
            end
            1: ds = $urandom;
            2: case ($urandom_range(0, 3))
                  0: ds = '0;
                  1: ds = 32'd1;
                  2: ds = 32'hFFFFFFFF;
                  default: ds = 32'h80000000;
               endcase
            default: ds = ($urandom_range(0, 1) == 1) ? dd : neg(dd);
         endcase
         if ($urandom_range(0, 7) == 0) dd = 32'h80000000;
         run_div("rand", dd, ds);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish by 2000000");
      $fatal(1, "watchdog expired");
   end

endmodule
